shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The block SHALL have the following ports, one clock domain, each listed as name  direction  width  meaning:
- clock  in  1  sole clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid[1:0]  in  2  per-requester request valid; bit i = requester i.
- req_ready[1:0]  out  2  per-requester accept; transfer when valid and ready are both high.
- req0_data / req1_data  in  32 each  operand to shift.
- req0_shamt / req1_shamt  in  5 each  shift amount 0..31.
- req0_op / req1_op  in  2 each  00 SLL, 01 SRL, 10 SRA, 11 ROL.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_data  out  32  shifted result.
- rsp_id  out  1  index of the requester that owns rsp_data.
REQ-002 The block SHALL have no parameters; widths are fixed at 32-bit data and 5-bit shift amount.

Function
REQ-003 The block SHALL time-share one combinational shift datapath between two requesters, with a single-entry registered output slot.
REQ-004 Slot states SHALL be EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-005 The slot SHALL be able to accept a request when EMPTY, or when FULL with rsp_ready=1 (drain and refill in the same cycle).
REQ-006 When the slot can accept, the grant SHALL be:
- exactly one requester valid: grant that requester;
- both valid: grant the requester not granted most recently.
REQ-007 req_ready SHALL be high only on the granted bit, only when the slot can accept, and SHALL be combinational from req_valid, the slot state and rsp_ready.
REQ-008 On a transfer, the slot SHALL capture the shifted result and grant index and go FULL on the next edge.
REQ-009 Latency SHALL be 1 cycle from accept to rsp_valid; sustained throughput SHALL be 1 result per cycle when rsp_ready=1.
REQ-010 Shift semantics:
- SLL zero-fills;
- SRL zero-fills;
- SRA replicates data[31];
- ROL rotates left by shamt;
- shamt=0 returns data unchanged for every op.
REQ-011 While FULL and rsp_ready=0, rsp_data, rsp_id and rsp_valid SHALL hold stable, and req_ready SHALL be 2'b00.
REQ-012 FULL, rsp_ready=1 and no request valid SHALL make the slot EMPTY on the next edge.
REQ-013 The last-grant pointer SHALL update only on a transfer.
REQ-014 Requester inputs SHALL be sampled only in the cycle they transfer.

Reset
REQ-015 Asserting reset_n low SHALL immediately force, independent of clock:
- rsp_valid=0, rsp_data=0, rsp_id=0;
- slot EMPTY;
- last-grant pointer=1, so requester 0 wins the first contended cycle.
REQ-016 A result held in the slot at reset SHALL be discarded; a handshake in flight at reset SHALL be lost.
REQ-017 req_ready SHALL be 2'b00 while reset_n is low.

Configuration
REQ-018 With macro SHIFT_ARBITER_ROTATE_EN defined, op 11 SHALL perform ROL.
REQ-019 Without SHIFT_ARBITER_ROTATE_EN, op 11 SHALL behave exactly as SLL and no rotate logic SHALL be synthesized.

Structure
REQ-020 Op encodings (SLL/SRL/SRA/ROL) SHALL be constants in shared package shift_arb_pkg, used by the block and the bench.
REQ-021 The datapath SHALL be one combinational sub-module, shift_core (data, shamt, op in; result out), built as log2 stages of 1/2/4/8/16; the arbiter and slot logic SHALL stay in shift_arbiter.

Verification
REQ-022 Single request: req0 data=0x0000_0001, shamt=4, SLL, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=0x0000_0010, rsp_id=0.
REQ-023 Arithmetic vs logical: 0x8000_0000 shamt=31 -> SRA gives 0xFFFF_FFFF, SRL gives 0x0000_0001; shamt=0 returns the operand unchanged.
REQ-024 Contention: both requesters valid continuously after reset, rsp_ready=1 -> grants alternate 0,1,0,1, with one rsp per cycle and rsp_id matching.
REQ-025 Backpressure: rsp_ready=0 for 3 cycles while FULL -> rsp_data stable and req_ready=00; when rsp_ready rises, drain and refill occur in the same cycle.
REQ-026 Rotate: 0x8000_0001 shamt=1 op=11 -> 0x0000_0003 with SHIFT_ARBITER_ROTATE_EN, 0x0000_0002 without.
REQ-027 Reset mid-operation: reset_n low asynchronously while FULL -> rsp_valid=0 immediately; the next contended grant goes to requester 0.

Source files
------------

// File: rtl/shift_arb_pkg.sv
// Purpose   : shared op encodings and slot-state type for the shift arbiter and its bench.
// Latency   : n/a (constants and types only).
// Backpress.: n/a.
package shift_arb_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

endpackage

// File: rtl/shift_arbiter_core.sv
// Purpose   : combinational 32-bit shifter (SLL/SRL/SRA, optional ROL), log2 stages 1/2/4/8/16.
// Latency   : 0 cycles, purely combinational.
// Backpress.: none; no handshake at this level.
// Ports: data_i[31:0], shamt_i[4:0], op_i[1:0] in; result_o[31:0] out.
// Build option SHIFT_ARBITER_ROTATE_EN: when defined op 11 rotates left, otherwise op 11 is SLL
// and no rotate path exists in the netlist.
module shift_core
    import shift_arb_pkg::*;
(
    input  logic [DATA_W-1:0]  data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [1:0]         op_i,
    output logic [DATA_W-1:0]  result_o
);

    logic do_right;
    logic do_arith;
`ifdef SHIFT_ARBITER_ROTATE_EN
    logic do_rol;
    assign do_rol = (op_i == OP_ROL);
`endif

    assign do_right = (op_i == OP_SRL) || (op_i == OP_SRA);
    assign do_arith = (op_i == OP_SRA);

    // Each shamt bit enables one fixed-distance stage. For SRA the sign bit is
    // preserved by every stage, so chaining arithmetic stages stays correct.
    always_comb begin
        logic [DATA_W-1:0] cur;
        cur = data_i;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (shamt_i[i]) begin
                if (do_right) begin
                    if (do_arith) begin
                        cur = $signed(cur) >>> (1 << i);
                    end else begin
                        cur = cur >> (1 << i);
                    end
                end
`ifdef SHIFT_ARBITER_ROTATE_EN
                else if (do_rol) begin
                    cur = (cur << (1 << i)) | (cur >> (DATA_W - (1 << i)));
                end
`endif
                else begin
                    cur = cur << (1 << i);
                end
            end
        end
        result_o = cur;
    end

endmodule

// File: rtl/shift_arbiter.sv
// Purpose   : two requesters time-share one shifter; result held in a single registered slot.
// Latency   : 1 cycle accept-to-rsp_valid; 1 result/cycle sustained with rsp_ready high.
// Backpress.: slot FULL and rsp_ready low -> req_ready=00 and outputs hold; drain+refill same cycle.
// Ports: clock, reset_n (async active-low); req_valid/req_ready[1:0]; req{0,1}_data/shamt/op;
//        rsp_valid/rsp_ready, rsp_data[31:0], rsp_id.
// Build option SHIFT_ARBITER_ROTATE_EN enables ROL for op 11 (see shift_core).
module shift_arbiter
    import shift_arb_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [DATA_W-1:0]   req0_data,
    input  logic [SHAMT_W-1:0]  req0_shamt,
    input  logic [1:0]          req0_op,
    input  logic [DATA_W-1:0]   req1_data,
    input  logic [SHAMT_W-1:0]  req1_shamt,
    input  logic [1:0]          req1_op,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_id
);

    slot_e              slot_q, slot_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               rsp_id_q, rsp_id_d;
    logic               last_q, last_d;   // requester granted most recently

    logic               can_accept;
    logic               grant;
    logic               transfer;
    logic [DATA_W-1:0]  sel_data;
    logic [SHAMT_W-1:0] sel_shamt;
    logic [1:0]         sel_op;
    logic [DATA_W-1:0]  shift_result;

    assign can_accept = (slot_q == SLOT_EMPTY) || rsp_ready;

    // Contended: the one not granted last. Otherwise whichever is valid.
    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b11) begin
            grant = ~last_q;
        end else if (req_valid[1]) begin
            grant = 1'b1;
        end
    end

    // reset_n gating keeps req_ready low while reset holds the slot EMPTY.
    always_comb begin
        req_ready = 2'b00;
        if (reset_n && can_accept && (req_valid != 2'b00)) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign transfer = |(req_valid & req_ready);

    assign sel_data  = grant ? req1_data  : req0_data;
    assign sel_shamt = grant ? req1_shamt : req0_shamt;
    assign sel_op    = grant ? req1_op    : req0_op;

    shift_core u_core (
        .data_i   (sel_data),
        .shamt_i  (sel_shamt),
        .op_i     (sel_op),
        .result_o (shift_result)
    );

    always_comb begin
        slot_d     = slot_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        last_d     = last_q;
        case (slot_q)
            SLOT_EMPTY: begin
                if (transfer) begin
                    slot_d = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (transfer) begin
                    slot_d = SLOT_FULL;
                end else if (rsp_ready) begin
                    slot_d = SLOT_EMPTY;
                end
            end
            default: slot_d = SLOT_EMPTY;
        endcase
        if (transfer) begin
            rsp_data_d = shift_result;
            rsp_id_d   = grant;
            last_d     = grant;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_q     <= SLOT_EMPTY;
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
            last_q     <= 1'b1;
        end else begin
            slot_q     <= slot_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            last_q     <= last_d;
        end
    end

    assign rsp_valid = (slot_q == SLOT_FULL);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Purpose   : scoreboard bench for shift_arbiter with directed vectors.
// Latency   : n/a.
// Backpress.: drives rsp_ready to exercise hold and drain+refill.
module tb_shift_arbiter;
    import shift_arb_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req0_data, req1_data;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [1:0]  req0_op, req1_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_id;

    int checks = 0;
    int errors = 0;
    logic [32:0] sb_q[$];   // {id, data}

    shift_arbiter dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_data  (req0_data),
        .req0_shamt (req0_shamt),
        .req0_op    (req0_op),
        .req1_data  (req1_data),
        .req1_shamt (req1_shamt),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic id, input logic [31:0] d);
        sb_q.push_back({id, d});
    endtask

    // Monitor: every consumed response is compared against the queue head.
    always @(negedge clock) begin
        if (reset_n && rsp_valid && rsp_ready) begin
            logic [32:0] e;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d data=0x%08h with empty scoreboard", rsp_id, rsp_data);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_id", {31'd0, rsp_id}, {31'd0, e[32]});
                chk("rsp_data", rsp_data, e[31:0]);
            end
        end
    end

    // Single-requester transfer; expected result pushed when the handshake is seen.
    task automatic xfer(input logic id, input logic [31:0] d, input logic [4:0] s,
                        input logic [1:0] op, input logic [31:0] exp);
        bit got;
        if (id == 1'b0) begin
            req0_data = d; req0_shamt = s; req0_op = op;
        end else begin
            req1_data = d; req1_shamt = s; req1_op = op;
        end
        req_valid = 2'b01 << id;
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clock);
            if (req_ready[id]) got = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout: requester %0d never got req_ready", id);
        end else begin
            push(id, exp);
        end
        @(posedge clock); #1;
        req_valid = 2'b00;
    endtask

    initial begin
        logic [31:0] rol_exp1, rol_exp8;
`ifdef SHIFT_ARBITER_ROTATE_EN
        rol_exp1 = 32'h0000_0003;
        rol_exp8 = 32'h3456_7812;
`else
        rol_exp1 = 32'h0000_0002;
        rol_exp8 = 32'h3456_7800;
`endif
        reset_n   = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        req0_data = '0; req0_shamt = '0; req0_op = OP_SLL;
        req1_data = '0; req1_shamt = '0; req1_op = OP_SLL;
        #2;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        req_valid = 2'b00;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        // Contention: 0,1,0,1 with one response per cycle.
        req0_data = 32'h0000_0001; req0_shamt = 5'd1; req0_op = OP_SLL;
        req1_data = 32'h0000_0100; req1_shamt = 5'd4; req1_op = OP_SRL;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("cont_grant", {30'd0, req_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
            if (k > 0) chk("cont_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            if (k % 2 == 0) push(1'b0, 32'h0000_0002);
            else            push(1'b1, 32'h0000_0010);
            @(posedge clock); #1;
        end
        req_valid = 2'b00;
        @(posedge clock); #1;

        // Directed shift vectors.
        xfer(1'b0, 32'h0000_0001, 5'd4,  OP_SLL, 32'h0000_0010);
        xfer(1'b0, 32'h8000_0000, 5'd31, OP_SRA, 32'hFFFF_FFFF);
        xfer(1'b1, 32'h8000_0000, 5'd31, OP_SRL, 32'h0000_0001);
        xfer(1'b0, 32'h8000_1234, 5'd0,  OP_SRA, 32'h8000_1234);
        xfer(1'b1, 32'hCAFE_BABE, 5'd0,  OP_ROL, 32'hCAFE_BABE);
        xfer(1'b1, 32'hF0F0_0000, 5'd4,  OP_SRA, 32'hFF0F_0000);
        xfer(1'b0, 32'h1234_5678, 5'd8,  OP_SLL, 32'h3456_7800);
        xfer(1'b1, 32'hDEAD_BEEF, 5'd16, OP_SRL, 32'h0000_DEAD);
        xfer(1'b0, 32'h8000_0001, 5'd1,  OP_ROL, rol_exp1);
        xfer(1'b1, 32'h1234_5678, 5'd8,  OP_ROL, rol_exp8);
        repeat (2) @(posedge clock); #1;

        // Backpressure: hold for 3 cycles, then drain and refill together.
        rsp_ready = 1'b0;
        req0_data = 32'h0000_00FF; req0_shamt = 5'd8; req0_op = OP_SLL;
        req_valid = 2'b01;
        @(negedge clock);
        chk("bp_accept", {30'd0, req_ready}, 32'd1);
        push(1'b0, 32'h0000_FF00);
        @(posedge clock); #1;
        req0_data = 32'h0F00_0000; req0_shamt = 5'd24; req0_op = OP_SRL;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_data", rsp_data, 32'h0000_FF00);
            chk("bp_req_ready", {30'd0, req_ready}, 32'd0);
            @(posedge clock); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        chk("bp_refill", {30'd0, req_ready}, 32'd1);
        push(1'b0, 32'h0000_000F);
        @(posedge clock); #1;
        req_valid = 2'b00;
        @(posedge clock); #1;
        @(negedge clock);
        chk("drain_empty", {31'd0, rsp_valid}, 32'd0);

        // Asynchronous reset while FULL.
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        xfer(1'b1, 32'h0000_0005, 5'd2, OP_SLL, 32'h0000_0014);
        @(negedge clock);
        chk("pre_rst_full", {31'd0, rsp_valid}, 32'd1);
        #2;
        reset_n = 1'b0;
        void'(sb_q.pop_back());   // held result is discarded by reset
        req0_data = 32'h0000_0003; req0_shamt = 5'd3; req0_op = OP_SLL;
        req1_data = 32'h0000_0003; req1_shamt = 5'd1; req1_op = OP_SLL;
        req_valid = 2'b11;
        #1;
        chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("arst_rsp_data", rsp_data, 32'd0);
        chk("arst_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("arst_req_ready", {30'd0, req_ready}, 32'd0);
        @(posedge clock); #1;
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clock);
        chk("post_rst_grant", {30'd0, req_ready}, 32'd1);
        push(1'b0, 32'h0000_0018);
        @(posedge clock); #1;
        req_valid = 2'b00;
        repeat (3) @(posedge clock);
        #1;
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
